pam4_channel_model: RTL
=======================

PAM4_CHANNEL_MODEL -- requirements
Module: pam4_channel_model

Interface
REQ-001 SHALL have parameter PULSE_RESPONSE_LENGTH, default 2, number of pulse-response taps L (1..16).
REQ-002 SHALL have parameter SIGNAL_RESOLUTION, default 8, signed output width W.
REQ-003 SHALL have parameter SYMBOL_SEPERATION, default 56, PAM4 level spacing S.
REQ-004 SHALL have parameter COEF_WIDTH, default 8, signed tap width; COEF_FRAC, default 6, tap fractional bits (64 = 1.0).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have ports start and stop, input, 1 each, single-cycle run-control pulses.
REQ-008 SHALL have ports symbol_in, input, 2, Gray-coded PAM4 symbol; symbol_in_valid, input, 1; symbol_in_ready, output, 1.
REQ-009 SHALL have ports noise, input, 8, signed additive noise sample; noise_enable, input, 1.
REQ-010 SHALL have ports coef_wr_en, input, 1; coef_wr_addr, input, 4; coef_wr_data, input, COEF_WIDTH, signed.
REQ-011 SHALL have ports signal_out, output, W, signed received sample; signal_out_valid, output, 1; done, output, 1.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE once the pipeline is empty.
REQ-013 SHALL, in IDLE, accept start over stop when both are high; stop in IDLE and start outside IDLE SHALL be ignored.
REQ-014 SHALL drive symbol_in_ready high only in RUN; a symbol is accepted when symbol_in_valid and symbol_in_ready are both high.
REQ-015 SHALL, on a RUN-cycle stop with an accepted symbol, process that symbol before draining.
REQ-016 SHALL map symbols: 00 -> -3S/2 (-84), 01 -> -S/2 (-28), 11 -> +S/2 (+28), 10 -> +3S/2 (+84).
REQ-017 SHALL shift each accepted level into an L-deep history x[0..L-1], x[0] newest; idle cycles in RUN SHALL NOT shift.
REQ-018 SHALL, in DRAIN, inject L-1 zero-level entries (one per cycle), each producing an output sample (ISI tail); L=1 injects none.
REQ-019 SHALL compute acc = sum h[k]*x[k] at full precision (no intermediate overflow), then y = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up).
REQ-020 SHALL add noise to y when noise_enable is high (sampled with the symbol's stage-2 cycle), then saturate to [-2^(W-1), 2^(W-1)-1].
REQ-021 SHALL be a 2-stage pipeline: signal_out_valid high exactly 2 cycles after each accept or drain injection, one cycle per sample, signal_out held between valids.
REQ-022 SHALL accept coefficient writes only in IDLE; writes with coef_wr_addr >= L or outside IDLE SHALL be ignored.
REQ-023 SHALL clear history to zero on entry to IDLE from DRAIN; taps SHALL persist across runs.
REQ-024 SHALL pulse done high for exactly one cycle on the DRAIN->IDLE transition, after the last drain signal_out_valid.

Reset
REQ-025 SHALL, on rstn low at a clock edge, set state IDLE, signal_out 0, signal_out_valid 0, symbol_in_ready 0, done 0, history 0, discard in-flight pipeline data.
REQ-026 SHALL reset taps to h[0]=64 (1.0), h[1]=32 (0.5), h[k>=2]=0.
REQ-027 SHALL honour reset mid-RUN or mid-DRAIN with no output valid in the following cycle.

Verification
REQ-028 Reset, start, symbol 10, stop, default taps, noise off -> outputs 84 then 42, then done pulse, state IDLE.
REQ-029 Symbols 10 then 01 back-to-back, default taps -> outputs 84, 14 (-28+42), drain -14, latency 2 cycles each.
REQ-030 h[0]=127 written in IDLE, symbol 10 -> raw 166.7, rounded 167, saturated output 127; symbol 00 -> -128.
REQ-031 noise_enable=1, noise=-5, symbol 11, default taps -> output 23.
REQ-032 coef_wr_en during RUN (h[0]=0) -> ignored, symbol 11 still gives 28; start+stop together in IDLE -> enters RUN.
REQ-033 rstn low during DRAIN -> next cycle signal_out_valid 0, done 0, taps back to 64/32, IDLE.

Source files
------------

// File: rtl/pam4_channel_model.sv
// PAM4 channel model: Gray-coded symbols are mapped to PAM4 levels, pushed
// through an L-tap pulse response (ISI), optionally corrupted with additive
// noise, and saturated to a signed W-bit received sample.
//
// Input handshake: symbol_in_ready is high only while running; a symbol is
// taken on a rising edge where symbol_in_valid and symbol_in_ready are both
// high. There is no output back-pressure: signal_out_valid pulses for one
// cycle per sample, two cycles after the symbol (or drain entry) was taken,
// and signal_out holds its value between valid pulses.
//
// Run control: start (IDLE->RUN), stop (RUN->DRAIN). DRAIN pushes L-1 zero
// levels to flush the ISI tail, waits for the pipeline to empty, then returns
// to IDLE and pulses done. Debug state encoding: IDLE=0, RUN=1, DRAIN=2.
module pam4_channel_model #(
    parameter int PULSE_RESPONSE_LENGTH = 2,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56,
    parameter int COEF_WIDTH            = 8,
    parameter int COEF_FRAC             = 6
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic [1:0]                           symbol_in,
    input  logic                                 symbol_in_valid,
    output logic                                 symbol_in_ready,
    input  logic signed [7:0]                    noise,
    input  logic                                 noise_enable,
    input  logic                                 coef_wr_en,
    input  logic [3:0]                           coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0]         coef_wr_data,
    output logic signed [SIGNAL_RESOLUTION-1:0]  signal_out,
    output logic                                 signal_out_valid,
    output logic                                 done,
    output logic [1:0]                           dbg_state_o
);

    localparam int L      = PULSE_RESPONSE_LENGTH;
    localparam int W      = SIGNAL_RESOLUTION;
    localparam int LVL_W  = 12;                    // holds +/-3S/2 for any sane S
    localparam int ACC_W  = COEF_WIDTH + LVL_W + 5; // 16 full-scale products never overflow
    localparam int SUM_W  = ACC_W + 2;             // rounding + noise headroom

    localparam logic signed [LVL_W-1:0] LVL_OUTER = LVL_W'((3 * SYMBOL_SEPERATION) / 2);
    localparam logic signed [LVL_W-1:0] LVL_INNER = LVL_W'(SYMBOL_SEPERATION / 2);
    localparam logic signed [ACC_W-1:0] RND_HALF  = ACC_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [SUM_W-1:0] OUT_MAX   = SUM_W'((2 ** (W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] OUT_MIN   = SUM_W'(-(2 ** (W - 1)));
    localparam logic [4:0]              DRAIN_LEN = 5'(L - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [LVL_W-1:0]  hist_q [L];
    logic signed [COEF_WIDTH-1:0] tap_q [L];
    logic [4:0]               drain_cnt_q;
    logic                     stage1_valid_q;

    logic                     accept;
    logic                     inject;
    logic                     drain_done;
    logic                     shift_en;
    logic signed [LVL_W-1:0]  sym_lvl;
    logic signed [LVL_W-1:0]  shift_lvl;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  rnd_d;
    logic signed [SUM_W-1:0]  noise_ext;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [W-1:0]      sat_d;

    assign dbg_state_o = state_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start beats stop in IDLE, stray pulses elsewhere are ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)      state_d = ST_RUN;
            ST_RUN:   if (stop)       state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, drain injection and drain completion
    always_comb begin
        symbol_in_ready = (state_q == ST_RUN);
        accept          = (state_q == ST_RUN) && symbol_in_valid;
        inject          = (state_q == ST_DRAIN) && (drain_cnt_q < DRAIN_LEN);
        drain_done      = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LEN) && !stage1_valid_q;
        shift_en        = accept || inject;
        shift_lvl       = accept ? sym_lvl : '0;
    end

    // Gray-coded symbol to PAM4 level
    always_comb begin
        case (symbol_in)
            2'b00:   sym_lvl = -LVL_OUTER;
            2'b01:   sym_lvl = -LVL_INNER;
            2'b11:   sym_lvl =  LVL_INNER;
            default: sym_lvl =  LVL_OUTER;
        endcase
    end

    // Stage 2 datapath: full-precision FIR, round half up, noise, saturate
    always_comb begin
        acc_d = '0;
        for (int k = 0; k < L; k++) begin
            acc_d = acc_d + ACC_W'(tap_q[k]) * ACC_W'(hist_q[k]);
        end
        rnd_d     = (acc_d + RND_HALF) >>> COEF_FRAC;
        noise_ext = '0;
        if (noise_enable) begin
            noise_ext = SUM_W'(noise);
        end
        sum_d = SUM_W'(rnd_d) + noise_ext;
        if (sum_d > OUT_MAX) begin
            sat_d = W'(OUT_MAX);
        end else if (sum_d < OUT_MIN) begin
            sat_d = W'(OUT_MIN);
        end else begin
            sat_d = W'(sum_d);
        end
    end

    // History shift, drain counter, tap writes and registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < L; k++) begin
                hist_q[k] <= '0;
                if (k == 0) begin
                    tap_q[k] <= COEF_WIDTH'(2 ** COEF_FRAC);
                end else if (k == 1) begin
                    tap_q[k] <= COEF_WIDTH'(2 ** (COEF_FRAC - 1));
                end else begin
                    tap_q[k] <= '0;
                end
            end
            drain_cnt_q      <= '0;
            stage1_valid_q   <= 1'b0;
            signal_out       <= '0;
            signal_out_valid <= 1'b0;
            done             <= 1'b0;
        end else begin
            stage1_valid_q <= shift_en;
            if (shift_en) begin
                hist_q[0] <= shift_lvl;
                for (int k = 1; k < L; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
            // Leaving DRAIN starts the next run from a silent channel
            if (drain_done) begin
                for (int k = 0; k < L; k++) begin
                    hist_q[k] <= '0;
                end
            end
            if (inject) begin
                drain_cnt_q <= drain_cnt_q + 5'd1;
            end else if (state_q != ST_DRAIN) begin
                drain_cnt_q <= '0;
            end
            if ((state_q == ST_IDLE) && coef_wr_en) begin
                for (int k = 0; k < L; k++) begin
                    if (coef_wr_addr == 4'(k)) begin
                        tap_q[k] <= coef_wr_data;
                    end
                end
            end
            signal_out_valid <= stage1_valid_q;
            if (stage1_valid_q) begin
                signal_out <= sat_d;
            end
            done <= drain_done;
        end
    end

endmodule
